ahbl_splitter_n: RTL and testbench



---
 rtl/ahbl_pkg.sv | 21 ++
 rtl/ahbl_default_slave.sv | 52 +++++
 rtl/ahbl_splitter_n.sv | 131 +++++++++++++
 tb/tb_ahbl_splitter_n.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings: transfer types, response codes and the
// default-slave state enum used by the splitter.
package ahbl_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_OKAY = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_e;

endpackage

// File: rtl/ahbl_default_slave.sv
// Default slave: answers unmapped or aborted transfers with the two-beat
// AHB ERROR response (ERR1 stalls, ERR2 completes).
module ahbl_default_slave
  import ahbl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic err_start,
  input  logic abort,
  output logic hready,
  output logic hresp
);

  ds_state_e state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= DS_OKAY;
      hready <= 1'b1;
      hresp  <= HRESP_OKAY;
    end else begin
      case (state)
        DS_OKAY: if (err_start || abort) begin
          state  <= DS_ERR1;
          hready <= 1'b0;
          hresp  <= HRESP_ERROR;
        end
        DS_ERR1: begin
          state  <= DS_ERR2;
          hready <= 1'b1;
          hresp  <= HRESP_ERROR;
        end
        DS_ERR2: if (err_start) begin
          // another unmapped access was accepted on the completing beat
          state  <= DS_ERR1;
          hready <= 1'b0;
          hresp  <= HRESP_ERROR;
        end else begin
          state  <= DS_OKAY;
          hready <= 1'b1;
          hresp  <= HRESP_OKAY;
        end
        default: begin
          state  <= DS_OKAY;
          hready <= 1'b1;
          hresp  <= HRESP_OKAY;
        end
      endcase
    end
  end

endmodule

// File: rtl/ahbl_splitter_n.sv
// N-way AHB-Lite address decoder / response mux with built-in default slave.
// Define AHBL_SPLITTER_WDOG_EN to add the hung-slave watchdog and TIMEOUT flag.
module ahbl_splitter_n
  import ahbl_pkg::*;
#(
  parameter int N_SLAVES       = 8,
  parameter int DEC_BITS       = 4,
  parameter logic [N_SLAVES*DEC_BITS-1:0] BASES =
    {4'h7, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0},
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     HCLK,
  input  logic                     HRESET,
  input  logic [31:0]              HADDR,
  input  logic [1:0]               HTRANS,
  output logic                     HREADY,
  output logic [31:0]              HRDATA,
  output logic                     HRESP,
  output logic [N_SLAVES-1:0]      S_HSEL,
  input  logic [32*N_SLAVES-1:0]   S_HRDATA,
  input  logic [N_SLAVES-1:0]      S_HREADYOUT,
  input  logic [N_SLAVES-1:0]      S_HRESP,
  output logic                     TIMEOUT
);

  localparam int IW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;

  if (N_SLAVES < 1 || N_SLAVES > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
    $error("ahbl_splitter_n: parameter out of range");
  end

  logic [N_SLAVES-1:0]       match;
  logic                      hit;
  logic [IW-1:0]             hit_idx;
  logic [N_SLAVES-1:0][31:0] s_rdata;
  logic                      dp_valid, dp_err;
  logic [IW-1:0]             dp_idx;
  logic                      err_start, abort;
  logic                      ds_hready, ds_hresp;
  logic                      unused_ok;

  assign s_rdata   = S_HRDATA;
  assign unused_ok = ^{HTRANS[0], HADDR[31-DEC_BITS:0]};

  for (genvar i = 0; i < N_SLAVES; i++) begin : g_dec
    assign match[i] = (HADDR[31 -: DEC_BITS] == BASES[i*DEC_BITS +: DEC_BITS]);
  end

  // scan high to low so the lowest matching slot is the one left standing
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  always_comb begin
    S_HSEL = '0;
    if (HTRANS[1] && hit) S_HSEL[hit_idx] = 1'b1;
  end

  assign err_start = HREADY & HTRANS[1] & ~hit;

  // an abort hands the stalled data phase over to the default slave
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_err   <= 1'b0;
      dp_idx   <= '0;
    end else if (HREADY) begin
      dp_valid <= HTRANS[1] & hit;
      dp_err   <= HTRANS[1] & ~hit;
      dp_idx   <= hit_idx;
    end else if (abort) begin
      dp_valid <= 1'b0;
      dp_err   <= 1'b1;
    end
  end

  ahbl_default_slave u_dflt (
    .clk       (HCLK),
    .rst       (HRESET),
    .err_start (err_start),
    .abort     (abort),
    .hready    (ds_hready),
    .hresp     (ds_hresp)
  );

`ifdef AHBL_SPLITTER_WDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] wd_cnt;
  logic          stall;

  assign stall = dp_valid & ~S_HREADYOUT[dp_idx];
  assign abort = stall && (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wd_cnt  <= '0;
      TIMEOUT <= 1'b0;
    end else begin
      if (!stall)                           wd_cnt <= '0;
      else if (wd_cnt != CW'(TIMEOUT_CYCLES)) wd_cnt <= wd_cnt + 1'b1;
      if (abort) TIMEOUT <= 1'b1;
    end
  end
`else
  assign abort   = 1'b0;
  assign TIMEOUT = 1'b0;
`endif

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = HRESP_OKAY;
    if (dp_valid) begin
      HRDATA = s_rdata[dp_idx];
      HREADY = S_HREADYOUT[dp_idx];
      HRESP  = S_HRESP[dp_idx];
    end else if (dp_err) begin
      HREADY = ds_hready;
      HRESP  = ds_hresp;
    end
  end

endmodule

// File: tb/tb_ahbl_splitter_n.sv
// Directed bench for ahbl_splitter_n: transaction-level model plus a
// per-cycle compare process and hand-computed spot checks.
module tb_ahbl_splitter_n;

  localparam int T = 4;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY, HRESP, TIMEOUT;
  logic [31:0] HRDATA;
  logic [7:0]  S_HSEL;
  logic [7:0][31:0] s_rdata;
  logic [7:0]  s_ready, s_resp;

  int  n_chk = 0, n_pass = 0;
  bit  cmp_en = 1'b0;

  always #5 HCLK = ~HCLK;

  // slot 7 duplicates slot 2's tag, so tag 7 is unmapped and slot 7 never wins
  ahbl_splitter_n #(
    .N_SLAVES       (8),
    .DEC_BITS       (4),
    .BASES          ({4'h2, 4'h6, 4'h5, 4'h4, 4'h3, 4'h2, 4'h1, 4'h0}),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HREADY      (HREADY),
    .HRDATA      (HRDATA),
    .HRESP       (HRESP),
    .S_HSEL      (S_HSEL),
    .S_HRDATA    (s_rdata),
    .S_HREADYOUT (s_ready),
    .S_HRESP     (s_resp),
    .TIMEOUT     (TIMEOUT)
  );

`ifdef AHBL_SPLITTER_WDOG_EN
  localparam bit WDOG = 1'b1;
`else
  localparam bit WDOG = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // ---------------- model ----------------
  localparam int K_NONE = 0, K_MAP = 1, K_ERR = 2;
  int m_kind = K_NONE, m_slot = 0, m_beat = 0, m_wait = 0;
  bit m_to = 1'b0;

  function automatic int slot_of(input logic [31:0] a);
    return (a[31:28] < 4'd7) ? int'(a[31:28]) : -1;
  endfunction

  function automatic logic [7:0] hsel_of(input logic [31:0] a, input logic [1:0] t);
    if (t[1] && slot_of(a) >= 0) return 8'd1 << slot_of(a);
    return 8'd0;
  endfunction

  logic        m_rdy, m_resp;
  logic [31:0] m_data;
  assign m_rdy  = (m_kind == K_NONE) || (m_kind == K_ERR && m_beat == 1) ||
                  (m_kind == K_MAP && s_ready[m_slot]);
  assign m_resp = (m_kind == K_ERR) || (m_kind == K_MAP && s_resp[m_slot]);
  assign m_data = (m_kind == K_MAP) ? s_rdata[m_slot] : 32'h0;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      m_kind <= K_NONE; m_beat <= 0; m_wait <= 0; m_to <= 1'b0; m_slot <= 0;
    end else if (m_rdy) begin
      m_beat <= 0;
      m_wait <= 0;
      m_slot <= (slot_of(HADDR) < 0) ? 0 : slot_of(HADDR);
      m_kind <= !HTRANS[1] ? K_NONE : (slot_of(HADDR) >= 0 ? K_MAP : K_ERR);
    end else if (m_kind == K_ERR) begin
      m_beat <= 1;
    end else if (m_kind == K_MAP) begin
      m_wait <= m_wait + 1;
      if (WDOG && m_wait + 1 == T) begin
        m_kind <= K_ERR; m_beat <= 0; m_to <= 1'b1;
      end
    end
  end

  always @(negedge HCLK) begin
    if (cmp_en) begin
      chk("cmp_hready",  HREADY,  m_rdy);
      chk("cmp_hresp",   HRESP,   m_resp);
      chk("cmp_hrdata",  HRDATA,  m_data);
      chk("cmp_hsel",    S_HSEL,  hsel_of(HADDR, HTRANS));
      chk("cmp_timeout", TIMEOUT, m_to);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    HRESET = 1'b1; HADDR = '0; HTRANS = 2'b00;
    s_ready = '1; s_resp = '0;
    for (int i = 0; i < 8; i++) s_rdata[i] = 32'hA000_0000 + i;
    s_rdata[2] = 32'hDEAD_BEEF;
    s_rdata[3] = 32'h3333_3333;
    s_rdata[5] = 32'h5555_5555;
    repeat (2) step();
    HRESET = 1'b0; cmp_en = 1'b1;
    step();

    chk("rst_hready",  HREADY,  1);
    chk("rst_hresp",   HRESP,   0);
    chk("rst_hrdata",  HRDATA,  0);
    chk("rst_hsel",    S_HSEL,  0);
    chk("rst_timeout", TIMEOUT, 0);

    HADDR = 32'h2000_0010; HTRANS = 2'b10; #1;
    chk("rd2_hsel", S_HSEL, 8'b0000_0100);
    step(); HTRANS = 2'b00; #1;
    chk("rd2_hrdata", HRDATA, 32'hDEAD_BEEF);
    chk("rd2_hresp",  HRESP,  0);

    step(); HADDR = 32'hF000_0000; HTRANS = 2'b10; #1;
    chk("um_hsel", S_HSEL, 0);
    step(); HTRANS = 2'b00; #1;
    chk("um_e1_rdy", HREADY, 0); chk("um_e1_resp", HRESP, 1);
    step(); #1;
    chk("um_e2_rdy", HREADY, 1); chk("um_e2_resp", HRESP, 1);
    step(); #1;
    chk("um_ok_rdy", HREADY, 1); chk("um_ok_resp", HRESP, 0);

    // back-to-back unmapped: second address accepted on the ERR2 beat
    HADDR = 32'hF000_0000; HTRANS = 2'b10;
    step(); HADDR = 32'h7000_0000; #1;
    chk("bb_hsel_dup", S_HSEL, 0);
    chk("bb_e1a_rdy", HREADY, 0);
    step(); #1;
    chk("bb_e2a_rdy", HREADY, 1); chk("bb_e2a_resp", HRESP, 1);
    step(); HTRANS = 2'b00; #1;
    chk("bb_e1b_rdy", HREADY, 0); chk("bb_e1b_resp", HRESP, 1);
    step(); #1;
    chk("bb_e2b_rdy", HREADY, 1); chk("bb_e2b_resp", HRESP, 1);
    step(); #1;
    chk("bb_ok_rdy", HREADY, 1); chk("bb_ok_resp", HRESP, 0);

    // slot 3 stalls three cycles
    s_ready[3] = 1'b0; HADDR = 32'h3000_0004; HTRANS = 2'b10;
    step(); HTRANS = 2'b00;
    for (int k = 0; k < 3; k++) begin
      #1 chk("st3_wait_rdy", HREADY, 0);
      step();
    end
    s_ready[3] = 1'b1; #1;
    chk("st3_rdy", HREADY, 1); chk("st3_data", HRDATA, 32'h3333_3333);
    chk("st3_resp", HRESP, 0);

    // slave-originated ERROR passes straight through
    step(); s_resp[1] = 1'b1; HADDR = 32'h1000_0000; HTRANS = 2'b10;
    step(); HTRANS = 2'b00; #1;
    chk("se_rdy", HREADY, 1); chk("se_resp", HRESP, 1);
    step(); s_resp[1] = 1'b0;

    // slot 5 stuck low
    s_ready[5] = 1'b0; HADDR = 32'h5000_0000; HTRANS = 2'b10;
    step(); HTRANS = 2'b00;
`ifdef AHBL_SPLITTER_WDOG_EN
    for (int k = 0; k < T; k++) begin
      #1 chk("wd_wait_rdy", HREADY, 0);
      step();
    end
    #1;
    chk("wd_e1_rdy", HREADY, 0); chk("wd_e1_resp", HRESP, 1);
    chk("wd_e1_to", TIMEOUT, 1);
    step(); s_ready[5] = 1'b1; #1;
    chk("wd_e2_rdy", HREADY, 1); chk("wd_e2_resp", HRESP, 1);
    step(); #1;
    chk("wd_ok_resp", HRESP, 0); chk("wd_ok_data", HRDATA, 0);
    chk("wd_ok_to", TIMEOUT, 1);
`else
    for (int k = 0; k < T + 2; k++) begin
      #1 chk("ns_wait_rdy", HREADY, 0);
      chk("ns_wait_to", TIMEOUT, 0);
      step();
    end
    s_ready[5] = 1'b1; #1;
    chk("ns_rdy", HREADY, 1); chk("ns_data", HRDATA, 32'h5555_5555);
`endif
    step();

    // decode sweep over every tag
    for (int t = 0; t < 16; t++) begin
      HADDR = {t[3:0], 28'h000_0100};
      HTRANS = t[0] ? 2'b11 : 2'b10;
      step(); HTRANS = 2'b00;
      step(); step();
    end

    // reset while the default slave is in ERR1
    HADDR = 32'hF000_0000; HTRANS = 2'b10;
    step(); HTRANS = 2'b00; #1;
    chk("rr_e1_rdy", HREADY, 0);
`ifdef AHBL_SPLITTER_WDOG_EN
    chk("rr_to_sticky", TIMEOUT, 1);
`endif
    HRESET = 1'b1; #1;
    chk("rr_rst_rdy", HREADY, 1); chk("rr_rst_resp", HRESP, 0);
    chk("rr_rst_to", TIMEOUT, 0);
    step(); HRESET = 1'b0;
    step(); #1;
    chk("rr_after_rdy", HREADY, 1); chk("rr_after_resp", HRESP, 0);
    HADDR = 32'hF000_0000; HTRANS = 2'b10;
    step(); HTRANS = 2'b00; #1;
    chk("rr_post_e1_rdy", HREADY, 0); chk("rr_post_e1_resp", HRESP, 1);
    step(); step(); step();

    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
